// File: rtl/attack_encoder_if.sv
// rtl/attack_encoder_if.sv - player control inputs and attack outputs of the attack encoder
interface attack_encoder_if;
    logic        frame_tick;
    logic        enable;
    logic        btn_a;
    logic        btn_b;
    logic        stick_up;
    logic        stick_down;
    logic        stick_left;
    logic        stick_right;
    logic        facing;
    logic [31:0] attack;
    logic        busy;
    logic [1:0]  phase;

    modport master (
        output frame_tick, enable, btn_a, btn_b,
        output stick_up, stick_down, stick_left, stick_right, facing,
        input  attack, busy, phase
    );

    modport slave (
        input  frame_tick, enable, btn_a, btn_b,
        input  stick_up, stick_down, stick_left, stick_right, facing,
        output attack, busy, phase
    );
endinterface

// File: rtl/attack_encoder.sv
// rtl/attack_encoder.sv - button-to-attack encoder with startup/active/recovery frame phases
module attack_encoder #(
    parameter int unsigned A_SU  = 2,
    parameter int unsigned A_AC  = 3,
    parameter int unsigned A_RC  = 4,
    parameter int unsigned NB_SU = 4,
    parameter int unsigned NB_AC = 4,
    parameter int unsigned NB_RC = 6,
    parameter int unsigned UB_SU = 3,
    parameter int unsigned UB_AC = 6,
    parameter int unsigned UB_RC = 10,
    parameter int unsigned DB_SU = 5,
    parameter int unsigned DB_AC = 4,
    parameter int unsigned DB_RC = 8,
    parameter int unsigned SB_SU = 6,
    parameter int unsigned SB_AC = 5,
    parameter int unsigned SB_RC = 12
) (
    input  logic            clock,
    input  logic            reset,
    attack_encoder_if.slave bus
);

    // Encoding doubles as the phase output value.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STARTUP  = 2'd1,
        ACTIVE   = 2'd2,
        RECOVERY = 2'd3
    } state_t;

    // One-hot move, bit i maps to attack[5+i]: A, up-B, down-B, side-B left, side-B right, neutral B.
    localparam logic [5:0] MV_A  = 6'b000001;
    localparam logic [5:0] MV_UB = 6'b000010;
    localparam logic [5:0] MV_DB = 6'b000100;
    localparam logic [5:0] MV_SL = 6'b001000;
    localparam logic [5:0] MV_SR = 6'b010000;
    localparam logic [5:0] MV_NB = 6'b100000;

    state_t      state, state_n;
    logic [7:0]  count, count_n;
    logic [5:0]  move, move_n, b_move;
    logic        a_prev, b_prev;
    logic        a_edge, b_edge;

    // Length in frames of the given phase of the given move.
    function automatic logic [7:0] move_len(input logic [5:0] mv, input state_t ph);
        logic [7:0] su, ac, rc;
        if (mv[0]) begin
            su = 8'(A_SU);  ac = 8'(A_AC);  rc = 8'(A_RC);
        end else if (mv[1]) begin
            su = 8'(UB_SU); ac = 8'(UB_AC); rc = 8'(UB_RC);
        end else if (mv[2]) begin
            su = 8'(DB_SU); ac = 8'(DB_AC); rc = 8'(DB_RC);
        end else if (mv[3] || mv[4]) begin
            su = 8'(SB_SU); ac = 8'(SB_AC); rc = 8'(SB_RC);
        end else begin
            su = 8'(NB_SU); ac = 8'(NB_AC); rc = 8'(NB_RC);
        end
        case (ph)
            STARTUP:  move_len = su;
            ACTIVE:   move_len = ac;
            RECOVERY: move_len = rc;
            default:  move_len = 8'd0;
        endcase
    endfunction

    assign a_edge = bus.btn_a & ~a_prev;
    assign b_edge = bus.btn_b & ~b_prev;

    // B move chosen by stick; vertical beats horizontal, facing breaks a left+right tie.
    always_comb begin
        b_move = MV_NB;
        if (bus.stick_up)
            b_move = MV_UB;
        else if (bus.stick_down)
            b_move = MV_DB;
        else if (bus.stick_left && bus.stick_right)
            b_move = bus.facing ? MV_SR : MV_SL;
        else if (bus.stick_right)
            b_move = MV_SR;
        else if (bus.stick_left)
            b_move = MV_SL;
    end

    // Next state, phase counter and latched move.
    always_comb begin
        state_n = state;
        count_n = count;
        move_n  = move;
        if (!bus.enable) begin
            state_n = IDLE;
            count_n = 8'd0;
            move_n  = 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_edge) begin
                        state_n = STARTUP;
                        move_n  = MV_A;
                        count_n = move_len(MV_A, STARTUP);
                    end else if (b_edge) begin
                        state_n = STARTUP;
                        move_n  = b_move;
                        count_n = move_len(b_move, STARTUP);
                    end
                end
                default: begin
                    if (bus.frame_tick) begin
                        if (count == 8'd1) begin
                            case (state)
                                STARTUP: begin
                                    state_n = ACTIVE;
                                    count_n = move_len(move, ACTIVE);
                                end
                                ACTIVE: begin
                                    state_n = RECOVERY;
                                    count_n = move_len(move, RECOVERY);
                                end
                                default: begin
                                    state_n = IDLE;
                                    count_n = 8'd0;
                                    move_n  = 6'd0;
                                end
                            endcase
                        end else begin
                            count_n = count - 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    // State register; button history tracks every cycle, even while busy.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= 8'd0;
            move   <= 6'd0;
            a_prev <= 1'b0;
            b_prev <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            move   <= move_n;
            a_prev <= bus.btn_a;
            b_prev <= bus.btn_b;
        end
    end

    // Outputs registered from the next-state values so they line up with the state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            bus.attack <= 32'd0;
            bus.busy   <= 1'b0;
            bus.phase  <= 2'd0;
        end else begin
            bus.busy   <= (state_n != IDLE);
            bus.phase  <= state_n;
            bus.attack <= (state_n == IDLE) ? 32'd0
                        : {21'd0, move_n, 4'd0, (state_n == ACTIVE)};
        end
    end

endmodule

// File: tb/tb_attack_encoder.sv
// tb/tb_attack_encoder.sv - directed self-checking bench for attack_encoder
module tb_attack_encoder;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    attack_encoder_if bus ();

    attack_encoder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // One game frame: three quiet cycles then a tick cycle.
    task automatic frame();
        bus.frame_tick = 1'b0;
        repeat (3) cyc();
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
    endtask

    // Press buttons, then walk every frame of the move checking the attack word.
    task automatic run_move(input string tag, input logic a, input logic b,
                            input logic [31:0] word, input int su, input int ac,
                            input int rc, input logic tick_entry, input logic repress);
        bus.btn_a = a;
        bus.btn_b = b;
        bus.frame_tick = tick_entry;
        cyc();
        bus.frame_tick = 1'b0;
        for (int i = 0; i < su; i++) begin
            check({tag, "_su"}, bus.attack, word);
            check({tag, "_su_phase"}, 32'(bus.phase), 32'd1);
            frame();
        end
        if (repress) begin
            bus.btn_b = 1'b0;
            cyc();
            bus.btn_b = 1'b1;
            cyc();
        end
        for (int i = 0; i < ac; i++) begin
            check({tag, "_ac"}, bus.attack, word | 32'h1);
            check({tag, "_ac_busy"}, 32'(bus.busy), 32'd1);
            frame();
        end
        for (int i = 0; i < rc; i++) begin
            check({tag, "_rc"}, bus.attack, word);
            check({tag, "_rc_phase"}, 32'(bus.phase), 32'd3);
            frame();
        end
        check({tag, "_end"}, bus.attack, 32'h0);
        check({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_end_phase"}, 32'(bus.phase), 32'd0);
        cyc();
        cyc();
        check({tag, "_no_retrig"}, 32'(bus.phase), 32'd0);
        bus.btn_a = 1'b0;
        bus.btn_b = 1'b0;
        cyc();
    endtask

    task automatic set_stick(input logic up, input logic dn, input logic lf,
                             input logic rt, input logic fc);
        bus.stick_up    = up;
        bus.stick_down  = dn;
        bus.stick_left  = lf;
        bus.stick_right = rt;
        bus.facing      = fc;
    endtask

    initial begin
        reset          = 1'b0;
        bus.frame_tick = 1'b0;
        bus.enable     = 1'b1;
        bus.btn_a      = 1'b1;
        bus.btn_b      = 1'b0;
        set_stick(0, 0, 0, 0, 0);

        // Reset overrides a held button.
        cyc();
        cyc();
        check("rst_attack", bus.attack, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_phase", 32'(bus.phase), 32'd0);
        bus.btn_a = 1'b0;
        reset = 1'b1;
        cyc();
        check("idle_attack", bus.attack, 32'h0);

        // Plain A: 2/3/4 frames.
        run_move("a", 1, 0, 32'h20, 2, 3, 4, 1'b0, 1'b0);

        // Up-B with a re-press during ACTIVE that must be ignored.
        set_stick(1, 0, 0, 0, 0);
        run_move("upb", 0, 1, 32'h40, 3, 6, 10, 1'b0, 1'b1);

        // Side-B both directions, tie broken by facing.
        set_stick(0, 0, 1, 1, 1);
        run_move("sb_lr_f1", 0, 1, 32'h200, 6, 5, 12, 1'b0, 1'b0);
        set_stick(0, 0, 1, 1, 0);
        run_move("sb_lr_f0", 0, 1, 32'h100, 6, 5, 12, 1'b0, 1'b0);
        set_stick(0, 0, 0, 1, 0);
        run_move("sb_r", 0, 1, 32'h200, 6, 5, 12, 1'b0, 1'b0);

        // Neutral B, entered on a frame_tick cycle (no decrement on entry).
        set_stick(0, 0, 0, 0, 1);
        run_move("nb_tick", 0, 1, 32'h400, 4, 4, 6, 1'b1, 1'b0);

        // A and B same cycle with stick_down: A wins, entry on a tick too.
        set_stick(0, 1, 0, 0, 0);
        run_move("a_over_b", 1, 1, 32'h20, 2, 3, 4, 1'b1, 1'b0);

        // Down-B, enable dropped during ACTIVE.
        bus.btn_b = 1'b1;
        cyc();
        check("db_entry", bus.attack, 32'h80);
        repeat (5) frame();
        check("db_active", bus.attack, 32'h81);
        bus.enable = 1'b0;
        cyc();
        check("en_drop_attack", bus.attack, 32'h0);
        check("en_drop_busy", 32'(bus.busy), 32'd0);
        check("en_drop_phase", 32'(bus.phase), 32'd0);
        bus.enable = 1'b1;
        cyc();
        cyc();
        check("en_held_no_retrig", 32'(bus.phase), 32'd0);
        bus.btn_b = 1'b0;
        cyc();

        // enable low in IDLE blocks entry; held button then never retriggers.
        bus.enable = 1'b0;
        bus.btn_a  = 1'b1;
        cyc();
        check("en_block", 32'(bus.phase), 32'd0);
        bus.enable = 1'b1;
        cyc();
        check("en_block_held", bus.attack, 32'h0);
        bus.btn_a = 1'b0;
        cyc();

        // Side-B left, reset in RECOVERY, A held through reset release.
        set_stick(0, 0, 1, 0, 1);
        bus.btn_b = 1'b1;
        cyc();
        check("sl_entry", bus.attack, 32'h100);
        repeat (11) frame();
        check("sl_recovery", bus.attack, 32'h100);
        check("sl_recovery_phase", 32'(bus.phase), 32'd3);
        bus.btn_a = 1'b1;
        cyc();
        check("busy_edge_ignored", bus.attack, 32'h100);
        reset = 1'b0;
        cyc();
        check("mid_rst_attack", bus.attack, 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_phase", 32'(bus.phase), 32'd0);
        reset = 1'b1;
        cyc();
        check("post_rst_a", bus.attack, 32'h20);
        check("post_rst_phase", 32'(bus.phase), 32'd1);
        check("post_rst_busy", 32'(bus.busy), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/attack_encoder.md
ATTACK_ENCODER -- requirements
Module: attack_encoder

Interface
REQ-001 SHALL have parameters: A_SU=2, A_AC=3, A_RC=4; NB_SU=4, NB_AC=4, NB_RC=6; UB_SU=3, UB_AC=6, UB_RC=10; DB_SU=5, DB_AC=4, DB_RC=8; SB_SU=6, SB_AC=5, SB_RC=12 (startup/active/recovery lengths in frames, each 1..255).
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low; 0 at a rising edge resets the block.
REQ-004 frame_tick  input  1  one-cycle strobe per game frame; phase counters advance only on it.
REQ-005 enable  input  1  player may act; 0 = hitstun/dead.
REQ-006 btn_a, btn_b  input  1 each  raw attack buttons, synchronous to clock.
REQ-007 stick_up, stick_down, stick_left, stick_right  input  1 each  directional state.
REQ-008 facing  input  1  0 = facing left, 1 = facing right.
REQ-009 attack  output  32  attack word: [0] hit-active, [5] A, [6] up-B, [7] down-B, [8] side-B left, [9] side-B right, [10] neutral B; all other bits 0.
REQ-010 busy  output  1  high whenever FSM is not IDLE.
REQ-011 phase  output  2  0 IDLE, 1 STARTUP, 2 ACTIVE, 3 RECOVERY.

Function
REQ-012 All outputs SHALL be registered; FSM states IDLE, STARTUP, ACTIVE, RECOVERY.
REQ-013 Rising edge per button SHALL be btn AND NOT btn_prev; btn_prev registers update every cycle, including while busy.
REQ-014 In IDLE with enable=1, a rising edge SHALL at that clock edge enter STARTUP, latch the move bit, load counter with the move's SU value.
REQ-015 Move select: A edge wins over B edge in same cycle; for B: stick_up -> up-B, else stick_down -> down-B, else left/right -> side-B, else neutral B.
REQ-016 Side-B: left only -> bit 8; right only -> bit 9; both -> bit 9 if facing=1, else bit 8.
REQ-017 A frame_tick in the same cycle as move entry SHALL NOT decrement the counter.
REQ-018 In STARTUP/ACTIVE/RECOVERY, each frame_tick SHALL decrement counter; frame_tick with counter==1 SHALL move to next phase and load its length (STARTUP->ACTIVE->RECOVERY->IDLE).
REQ-019 attack SHALL carry the latched move bit in STARTUP, ACTIVE, RECOVERY; attack[0]=1 only in ACTIVE; attack=0 in IDLE.
REQ-020 Button edges while busy SHALL be ignored (no buffering); a held button SHALL NOT retrigger after return to IDLE.
REQ-021 enable=0 in any non-IDLE state SHALL force IDLE, attack=0, busy=0 at the next edge; enable=0 in IDLE SHALL block move entry.
REQ-022 Exactly one of bits 5..10 SHALL be set when busy; never more than one.

Reset
REQ-023 reset=0 at a rising edge SHALL set state IDLE, counter 0, attack=0, busy=0, phase=0, btn_prev=0, overriding all other inputs, including mid-move.
REQ-024 After reset release, a button already high SHALL count as a rising edge on the first cycle (btn_prev=0).

Verification
REQ-025 frame_tick every 4 cycles, btn_a pulse, no stick -> attack=0x20 for 2 frames, 0x21 for 3 frames, 0x20 for 4 frames, then 0x0; busy high throughout.
REQ-026 stick_up=1 + btn_b edge -> 0x40 for 3 frames, 0x41 for 6, 0x40 for 10; btn_b re-pressed during ACTIVE -> no effect.
REQ-027 stick_left=stick_right=1, facing=1, btn_b edge -> active word 0x201; facing=0 -> 0x101.
REQ-028 btn_a and btn_b rise same cycle with stick_down=1 -> A selected (0x20/0x21), not 0x80.
REQ-029 enable dropped during ACTIVE (attack=0x81) -> attack=0x0, busy=0, phase=0 next edge; held buttons then do not retrigger.
REQ-030 reset=0 for one cycle during RECOVERY of side-B -> all outputs 0 next edge; btn_a held high through release -> new A move starts first cycle after release.
